aes256_key_sched_ctrl: RTL and testbench
========================================

Name: aes256_key_sched_ctrl

Overview:
Sequential AES-256 key-expansion controller. Latches a 256-bit cipher key on start and generates the 15 round keys (rk0..rk14), one 128-bit key per handshake. It owns one g_transform instance (RotWord+SubWord+Rcon) and four sbox instances (SubWord-only h-step). It feeds round keys to the round datapath over a valid/ready stream with backpressure.

Parameters:
NUM_RK, 15, number of round keys emitted (fixed for AES-256; other values unsupported)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; accepted only in IDLE
key  input  256  cipher key, word0 in [255:224] (FIPS-197 byte order)
busy  output  1  high from accepted start until final handshake
rk_valid  output  1  round key available
rk_ready  input  1  consumer accepts round key
rk_idx  output  4  index of presented round key, 0..14
rk  output  128  round key, word0 in [127:96]
done  output  1  one-cycle pulse after rk14 handshake
rd_idx  input  4  cache read index (see Optional Feature)
rd_key  output  128  cache read data (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, rk_valid, done=0; rk_idx=0; rk=0; window regs H,L=0; rd_key=0.
- Window: H (older 128b), L (newer 128b). Load: H<=key[255:128], L<=key[127:0].
- FSM states: IDLE, EMIT.
  - IDLE: on start=1, load window, rk_idx<=0, busy<=1, go to EMIT. start ignored in every other state.
  - EMIT: rk_valid=1. rk = H when rk_idx==0, else L. rk/rk_idx are stable while rk_valid && !rk_ready.
  - Handshake (rk_valid && rk_ready) at rk_idx==0: rk_idx<=1. Window unchanged.
  - Handshake at 1<=rk_idx<=13: compute next key N (index k=rk_idx+1).
    - N0 = H0 ^ T; N1 = H1 ^ N0; N2 = H2 ^ N1; N3 = H3 ^ N2.
    - T = g_transform(L3, rnd=k/2) when k is even; T = SubWord(L3) (four sboxes, no rotate, no rcon) when k is odd.
    - Then H<=L, L<=N, rk_idx<=k.
  - Handshake at rk_idx==14: rk_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE. Window keeps its last value.
- rnd range applied to g_transform: 1..7. The whole N computation is a single-cycle combinational chain.
- Latency: rk_valid rises the cycle after start is accepted. With rk_ready held high, rk0..rk14 appear on 15 consecutive cycles and done pulses on the 16th.
- rk_ready while rk_valid=0 has no effect.
- Reset mid-expansion aborts immediately to the reset values. No partial state survives.
- start coincident with the final handshake is ignored. The block is still in EMIT that cycle.

Optional Feature:
Macro AES_KEY_CACHE_EN.
- Defined: a 15x128 register array stores each round key as it is handshaked, at address rk_idx.
  - rd_key <= cache[rd_idx] each cycle, 1-cycle latency. This lets decryption read keys in reverse order.
  - rd_idx>14 returns 0. Entries are valid only after done and are overwritten by the next expansion.
  - Reset clears the array.
- Undefined: no array; rd_idx is ignored and rd_key is constant 0.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, rk_ready=1 -> rk0=603deb1015ca71be2b73aef0857d7781, rk1=1f352c073b6108d72d9810a30914dff4, rk2=9ba354118e6925afa51a8b5f2067fcde, rk3=a8b09c1a93d194cdbe49846eb75d5b9a, rk14=fe4890d1e6188d0b046df344706c631e; done pulses the cycle after rk14.
- Same key, rk_ready toggled 1,0,0,1 pseudo-randomly -> rk/rk_idx stable while stalled; identical key sequence; exactly 15 handshakes.
- start pulsed again at rk_idx=5 -> ignored; sequence continues to rk14 unchanged.
- rst_n asserted at rk_idx=7 -> rk_valid, busy, rk_idx, rk drop to 0 asynchronously. A new start after release restarts from rk0.
- All-zero key -> rk2=62636363626363636263636362636363, rk3=aafbfbfbaafbfbfbaafbfbfbaafbfbfb.
- AES_KEY_CACHE_EN defined, after A.3 done: rd_idx=14 -> rd_key=fe4890d1e6188d0b046df344706c631e one cycle later; rd_idx=15 -> 0. Undefined: rd_key stays 0.

Source files
------------

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-expansion controller: latches a 256b key and streams rk0..rk14 (128b each); optional AES_KEY_CACHE_EN round-key cache.
// Latency: rk0 valid the cycle after start; one key per cycle with rk_ready high; done pulses the cycle after rk14.
// Backpressure: rk/rk_idx hold while rk_valid && !rk_ready; the window only advances on a handshake.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  logic [7:0] x2, x3, x12, x14, x15, x240, inv;
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x14  = gmul(x12, x2);
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
    x240 = gmul(x240, x240);
    inv  = gmul(x240, x14);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_g_transform (
  input  logic [31:0] w,
  input  logic [2:0]  rnd,
  output logic [31:0] g
);
  logic [31:0] rot;
  logic [31:0] sub;
  logic [7:0]  rcon;

  assign rot  = {w[23:0], w[31:24]};
  assign rcon = 8'h01 << (rnd - 3'd1);

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
  end

  assign g = {sub[31:24] ^ rcon, sub[23:0]};
endmodule

module aes256_key_sched_ctrl #(
  parameter int NUM_RK = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

  state_t       state_q, state_d;
  logic         busy_q, busy_d;
  logic         rk_valid_q, rk_valid_d;
  logic         done_q, done_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic [127:0] h_q, h_d;
  logic [127:0] l_q, l_d;

  logic         rk_hs;
  logic [3:0]   k_idx;
  logic [31:0]  g_out, h_sub, t_word;
  logic [127:0] nxt;

  assign rk_hs = rk_valid_q && rk_ready;
  assign k_idx = rk_idx_q + 4'd1;

  aes_g_transform u_g (.w(l_q[31:0]), .rnd(k_idx[3:1]), .g(g_out));

  for (genvar i = 0; i < 4; i++) begin : g_hsb
    aes_sbox u_sbox (.a(l_q[8*i +: 8]), .s(h_sub[8*i +: 8]));
  end

  // Even target index uses the full g-step, odd uses the SubWord-only h-step.
  assign t_word = k_idx[0] ? h_sub : g_out;
  always_comb begin
    nxt[127:96] = h_q[127:96] ^ t_word;
    nxt[95:64]  = h_q[95:64]  ^ nxt[127:96];
    nxt[63:32]  = h_q[63:32]  ^ nxt[95:64];
    nxt[31:0]   = h_q[31:0]   ^ nxt[63:32];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    rk_idx_d   = rk_idx_q;
    h_d        = h_q;
    l_d        = l_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          h_d        = key[255:128];
          l_d        = key[127:0];
          rk_idx_d   = 4'd0;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (rk_hs) begin
          if (rk_idx_q == LAST_IDX) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else if (rk_idx_q == 4'd0) begin
            rk_idx_d = 4'd1;
          end else begin
            h_d      = l_q;
            l_d      = nxt;
            rk_idx_d = k_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rk_idx_q   <= 4'd0;
      h_q        <= '0;
      l_q        <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      rk_idx_q   <= rk_idx_d;
      h_q        <= h_d;
      l_q        <= l_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign done     = done_q;
  assign rk_idx   = rk_idx_q;
  assign rk       = (rk_idx_q == 4'd0) ? h_q : l_q;

`ifdef AES_KEY_CACHE_EN
  logic [127:0] cache_q [NUM_RK];
  logic [127:0] cache_d [NUM_RK];
  logic [127:0] rd_key_q, rd_key_d;

  always_comb begin
    cache_d = cache_q;
    if (rk_hs) cache_d[rk_idx_q] = rk;
    rd_key_d = (rd_idx < 4'(NUM_RK)) ? cache_q[rd_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RK; i++) cache_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      cache_q  <= cache_d;
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Scoreboard bench: a FIPS-197 word-array key expansion fills an expected queue; a negedge monitor checks every handshake.
module tb_aes256_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [255:0] key = '0;
  logic [3:0]   rd_idx = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk, rd_key;

  aes256_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk(rk),
    .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] model_rk [15];
  logic [131:0] exp_q [$];
  logic [127:0] got_rk [15];
  int           hs_cyc [15];
  int           hs_count = 0;
  int           done_cyc = 0;
  bit           done_seen = 0;
  bit           exp_done = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_rk;
  logic [3:0]   prev_idx;
  bit           rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done   = 0;
      prev_stall = 0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", 256'(done), 256'(1));
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
        exp_done = 0;
      end else if (done) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_spurious: got done=1 at cycle %0d, expected 0", cyc);
      end
      if (prev_stall) begin
        chk("stall_rk", rk, prev_rk);
        chk("stall_idx", 256'(rk_idx), 256'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rk: got idx %0d rk %0h, expected no key", rk_idx, rk);
        end else begin
          logic [131:0] e;
          e = exp_q.pop_front();
          chk("rk_idx", 256'(rk_idx), 256'(e[131:128]));
          chk("rk", rk, e[127:0]);
        end
        if (rk_idx < 4'd15) begin
          got_rk[rk_idx] = rk;
          hs_cyc[rk_idx] = cyc;
        end
        hs_count++;
        if (rk_idx == 4'd14) exp_done = 1;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk    = rk;
      prev_idx   = rk_idx;
    end
  end

  task automatic start_exp(input logic [255:0] k);
    model_expand(k);
    for (int j = 0; j < 15; j++) exp_q.push_back({4'(j), model_rk[j]});
    hs_count  = 0;
    done_seen = 0;
    key       = k;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("valid_after_start", 256'(rk_valid), 256'(1));
  endtask

  task automatic wait_done(input int inj_idx);
    bit injected;
    injected = 0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (!injected && rk_valid && rk_idx == 4'(inj_idx)) begin
        key      = ~key;
        start    = 1'b1;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!done_seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 400 cycles, expected done");
    end
    chk("hs_count", 256'(hs_count), 256'(15));
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    chk("busy_after_done", 256'(busy), 256'(0));
  endtask

  initial begin
    build_sbox();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_valid", 256'(rk_valid), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_idx", 256'(rk_idx), 256'(0));
    chk("rst_rk", rk, 256'(0));
    chk("rst_rd_key", rd_key, 256'(0));
    rst_n = 1'b1;
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // FIPS-197 A.3 with rk_ready held high
    start_exp(KEY_A3);
    wait_done(-1);
    chk("lat_rk0", 256'(hs_cyc[0]), 256'(start_cyc + 1));
    chk("lat_rk14", 256'(hs_cyc[14]), 256'(start_cyc + 15));
    chk("lat_done", 256'(done_cyc), 256'(start_cyc + 16));
    chk("a3_rk0", got_rk[0], 256'h603deb1015ca71be2b73aef0857d7781);
    chk("a3_rk1", got_rk[1], 256'h1f352c073b6108d72d9810a30914dff4);
    chk("a3_rk2", got_rk[2], 256'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a3_rk3", got_rk[3], 256'ha8b09c1a93d194cdbe49846eb75d5b9a);
    chk("a3_rk14", got_rk[14], 256'hfe4890d1e6188d0b046df344706c631e);

`ifdef AES_KEY_CACHE_EN
    for (int i = 14; i >= 0; i--) begin
      rd_idx = 4'(i);
      @(posedge clk);
      #1;
      chk("cache_rd", rd_key, 256'(model_rk[i]));
    end
    rd_idx = 4'd15;
    @(posedge clk);
    #1;
    chk("cache_rd_oob", rd_key, 256'(0));
`else
    rd_idx = 4'd14;
    @(posedge clk);
    #1;
    chk("rd_key_disabled", rd_key, 256'(0));
`endif

    // random backpressure, stray start at rk_idx 5
    rand_ready = 1;
    start_exp(KEY_A3);
    wait_done(5);
    chk("a3_rand_rk14", got_rk[14], 256'hfe4890d1e6188d0b046df344706c631e);

    // reset mid-expansion at rk_idx 7
    rand_ready = 0;
    start_exp({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    for (int c = 0; c < 100 && rk_idx != 4'd7; c++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_idx7", 256'(rk_idx), 256'(7));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 256'(rk_valid), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_idx", 256'(rk_idx), 256'(0));
    chk("abort_rk", rk, 256'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_exp(KEY_A3);
    wait_done(-1);
    chk("restart_rk0", got_rk[0], 256'h603deb1015ca71be2b73aef0857d7781);

    // all-zero key
    start_exp('0);
    wait_done(-1);
    chk("zero_rk2", got_rk[2], 256'h62636363626363636263636362636363);
    chk("zero_rk3", got_rk[3], 256'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

    // random keys with random backpressure
    rand_ready = 1;
    for (int n = 0; n < 4; n++) begin
      start_exp({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_done(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
